// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter (ALU vs MEM) plus a 32-step zeroing sweep for register_mem.
// Define REGWB_ZERO_GUARD_EN to suppress the write strobe for any write to address 0.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_req,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ack,
    input  logic        mem_req,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ack,
    input  logic        clr_req,
    output logic        busy,
    output logic        clr_done,
    output logic [4:0]  w_reg_addr,
    output logic [31:0] w_data,
    output logic        reg_w
);
    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic        r_last_mem;
    logic        r_clr_done;
    logic        r_reg_w;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    logic        w_alu_grant, w_mem_grant, w_start_clr;
    logic        w_wr_en, w_strobe;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_next = S_CLEAR;
            S_CLEAR: if (r_cnt == 5'd31) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Clear request in IDLE beats both requesters; last_grant breaks ties.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        w_start_clr = 1'b0;
        if (!rst && r_state == S_IDLE) begin
            if (clr_req) begin
                w_start_clr = 1'b1;
            end else begin
                w_alu_grant = alu_req && (!mem_req || r_last_mem);
                w_mem_grant = mem_req && !w_alu_grant;
            end
        end
    end

    assign alu_ack  = w_alu_grant;
    assign mem_ack  = w_mem_grant;
    assign busy     = (r_state == S_CLEAR);
    assign clr_done = r_clr_done;

    always_comb begin
        w_wr_addr = 5'd0;
        w_wr_data = 32'd0;
        if (r_state == S_CLEAR) begin
            w_wr_addr = r_cnt;
        end else if (w_alu_grant) begin
            w_wr_addr = alu_addr;
            w_wr_data = alu_data;
        end else if (w_mem_grant) begin
            w_wr_addr = mem_addr;
            w_wr_data = mem_data;
        end
    end

    assign w_wr_en = w_start_clr || busy || w_alu_grant || w_mem_grant;

`ifdef REGWB_ZERO_GUARD_EN
    assign w_strobe = w_wr_en && (w_wr_addr != 5'd0);
`else
    assign w_strobe = w_wr_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 5'd0;
            r_last_mem <= 1'b1;
            r_clr_done <= 1'b0;
            r_reg_w    <= 1'b0;
            r_addr     <= 5'd0;
            r_data     <= 32'd0;
        end else begin
            r_reg_w    <= w_strobe;
            r_clr_done <= busy && (r_cnt == 5'd31);
            if (w_wr_en) begin
                r_addr <= w_wr_addr;
                r_data <= w_wr_data;
            end
            // Counter wraps 31 -> 0 naturally as the sweep exits.
            if (w_start_clr)  r_cnt <= 5'd1;
            else if (busy)    r_cnt <= r_cnt + 5'd1;
            if (w_alu_grant)      r_last_mem <= 1'b0;
            else if (w_mem_grant) r_last_mem <= 1'b1;
        end
    end

    assign w_reg_addr = r_addr;
    assign w_data     = r_data;
    assign reg_w      = r_reg_w;
endmodule
